// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a level debouncer for one asynchronous input.
// Produces a clean level, single-cycle edge pulses and a saturating rejected-glitch count.
module debounce_sync #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // Index of the sample that completes qualification (counter starts at 1).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

  logic             s1_r;
  logic             s2_r;
  logic             sync_s;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dout_r;
  logic             rise_r;
  logic             fall_r;
  logic             busy_r;
  logic [7:0]       glitch_r;

  // Metastability synchroniser: plain two-flop chain, nothing in between.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
    end
  end

  assign sync_s = s2_r;

  // Debounce FSM with registered level, pulses, busy flag and glitch counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE_LO;
      cnt_r    <= CNT_ZERO;
      dout_r   <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      busy_r   <= 1'b0;
      glitch_r <= 8'd0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        IDLE_LO: begin
          if (sync_s) begin
            state_r <= WAIT_HI;
            cnt_r   <= CNT_ONE;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        WAIT_HI: begin
          if (!sync_s) begin
            state_r  <= IDLE_LO;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            glitch_r <= sat_inc8(glitch_r);
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE_HI;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            dout_r  <= 1'b1;
            rise_r  <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            busy_r  <= 1'b1;
          end
        end
        IDLE_HI: begin
          if (!sync_s) begin
            state_r <= WAIT_LO;
            cnt_r   <= CNT_ONE;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        WAIT_LO: begin
          if (sync_s) begin
            state_r  <= IDLE_HI;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            glitch_r <= sat_inc8(glitch_r);
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE_LO;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            dout_r  <= 1'b0;
            fall_r  <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE_LO;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
          dout_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_r;
  assign rise       = rise_r;
  assign fall       = fall_r;
  assign busy       = busy_r;
  assign glitch_cnt = glitch_r;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync with STABLE_CYCLES=4.
module tb_debounce_sync;

  logic       clk;
  logic       rstn;
  logic       din;
  logic       dout;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] glitch_cnt;

  int n_checks;
  int n_fail;

  debounce_sync #(.STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din        (din),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    din  = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    din  = 1'b1;
    repeat (4) tick();
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0", dout); end
    n_checks++;
    if (rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise: got %b expected 0", rise); end
    n_checks++;
    if (fall !== 1'b0) begin n_fail++; $display("FAIL reset_fall: got %b expected 0", fall); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_glitch: got %0d expected 0", glitch_cnt); end
    din = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_clean_rise();
    logic exp_busy;
    logic exp_rise;
    logic exp_dout;
    din = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_busy = (i >= 3 && i <= 5);
      exp_rise = (i == 6);
      exp_dout = (i >= 6);
      n_checks++;
      if (busy !== exp_busy) begin n_fail++; $display("FAIL rise_busy[%0d]: got %b expected %b", i, busy, exp_busy); end
      n_checks++;
      if (rise !== exp_rise) begin n_fail++; $display("FAIL rise_pulse[%0d]: got %b expected %b", i, rise, exp_rise); end
      n_checks++;
      if (dout !== exp_dout) begin n_fail++; $display("FAIL rise_dout[%0d]: got %b expected %b", i, dout, exp_dout); end
      n_checks++;
      if (fall !== 1'b0) begin n_fail++; $display("FAIL rise_fall[%0d]: got %b expected 0", i, fall); end
    end
    n_checks++;
    if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL rise_glitch: got %0d expected 0", glitch_cnt); end
  endtask

  task automatic test_clean_fall_bounce();
    logic [8:0] pat_din  = 9'b000000010;
    logic [8:0] exp_busy = 9'b001110100;
    logic [8:0] exp_fall = 9'b010000000;
    logic [8:0] exp_dout = 9'b001111111;
    for (int i = 0; i < 9; i++) begin
      din = pat_din[i];
      tick();
      n_checks++;
      if (busy !== exp_busy[i]) begin n_fail++; $display("FAIL fall_busy[%0d]: got %b expected %b", i, busy, exp_busy[i]); end
      n_checks++;
      if (fall !== exp_fall[i]) begin n_fail++; $display("FAIL fall_pulse[%0d]: got %b expected %b", i, fall, exp_fall[i]); end
      n_checks++;
      if (dout !== exp_dout[i]) begin n_fail++; $display("FAIL fall_dout[%0d]: got %b expected %b", i, dout, exp_dout[i]); end
      n_checks++;
      if (rise !== 1'b0) begin n_fail++; $display("FAIL fall_rise[%0d]: got %b expected 0", i, rise); end
      if (i == 2) begin
        n_checks++;
        if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL fall_glitch_pre: got %0d expected 0", glitch_cnt); end
      end
    end
    n_checks++;
    if (glitch_cnt !== 8'd1) begin n_fail++; $display("FAIL fall_glitch: got %0d expected 1", glitch_cnt); end
  endtask

  task automatic test_boundary_glitch();
    logic saw_rise;
    logic exp_rise;
    saw_rise = 1'b0;
    din = 1'b1;
    repeat (3) begin tick(); saw_rise |= rise; end
    din = 1'b0;
    repeat (6) begin tick(); saw_rise |= rise; end
    n_checks++;
    if (saw_rise !== 1'b0) begin n_fail++; $display("FAIL bnd3_rise: got %b expected 0", saw_rise); end
    n_checks++;
    if (dout !== 1'b0) begin n_fail++; $display("FAIL bnd3_dout: got %b expected 0", dout); end
    n_checks++;
    if (glitch_cnt !== 8'd2) begin n_fail++; $display("FAIL bnd3_glitch: got %0d expected 2", glitch_cnt); end
    din = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) din = 1'b0;
      tick();
      exp_rise = (i == 6);
      n_checks++;
      if (rise !== exp_rise) begin n_fail++; $display("FAIL bnd4_rise[%0d]: got %b expected %b", i, rise, exp_rise); end
    end
    n_checks++;
    if (dout !== 1'b1) begin n_fail++; $display("FAIL bnd4_dout: got %b expected 1", dout); end
    repeat (8) tick();
    n_checks++;
    if (dout !== 1'b0) begin n_fail++; $display("FAIL bnd4_settle: got %b expected 0", dout); end
    n_checks++;
    if (glitch_cnt !== 8'd2) begin n_fail++; $display("FAIL bnd4_glitch: got %0d expected 2", glitch_cnt); end
  endtask

  task automatic test_glitch_reject();
    logic saw_rise;
    saw_rise = 1'b0;
    for (int n = 0; n < 300; n++) begin
      din = 1'b1;
      repeat (2) begin tick(); saw_rise |= rise; end
      din = 1'b0;
      repeat (6) begin tick(); saw_rise |= rise; end
      if (n == 0) begin
        n_checks++;
        if (glitch_cnt !== 8'd3) begin n_fail++; $display("FAIL glitch_first: got %0d expected 3", glitch_cnt); end
      end
      if (n == 251) begin
        n_checks++;
        if (glitch_cnt !== 8'd254) begin n_fail++; $display("FAIL glitch_254: got %0d expected 254", glitch_cnt); end
      end
    end
    n_checks++;
    if (glitch_cnt !== 8'd255) begin n_fail++; $display("FAIL glitch_sat: got %0d expected 255", glitch_cnt); end
    n_checks++;
    if (saw_rise !== 1'b0) begin n_fail++; $display("FAIL glitch_rise: got %b expected 0", saw_rise); end
    n_checks++;
    if (dout !== 1'b0) begin n_fail++; $display("FAIL glitch_dout: got %b expected 0", dout); end
  endtask

  task automatic test_reset_mid_qual();
    logic exp_rise;
    logic saw_pulse;
    din = 1'b1;
    repeat (3) tick();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({dout, rise, fall, busy} !== 4'b0000) begin n_fail++; $display("FAIL midrst_outs: got %b expected 0000", {dout, rise, fall, busy}); end
    n_checks++;
    if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_glitch: got %0d expected 0", glitch_cnt); end
    tick();
    rstn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_rise = (i == 6);
      n_checks++;
      if (rise !== exp_rise) begin n_fail++; $display("FAIL midrst_rise[%0d]: got %b expected %b", i, rise, exp_rise); end
    end
    saw_pulse = 1'b0;
    repeat (10) begin
      tick();
      saw_pulse |= rise | fall | busy;
    end
    n_checks++;
    if (saw_pulse !== 1'b0) begin n_fail++; $display("FAIL steady_activity: got %b expected 0", saw_pulse); end
    n_checks++;
    if (dout !== 1'b1) begin n_fail++; $display("FAIL steady_dout: got %b expected 1", dout); end
    n_checks++;
    if (glitch_cnt !== 8'd0) begin n_fail++; $display("FAIL steady_glitch: got %0d expected 0", glitch_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    din      = 1'b0;
    test_reset();
    test_clean_rise();
    test_clean_fall_bounce();
    test_boundary_glitch();
    test_glitch_reject();
    test_reset_mid_qual();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
